// File: rtl/shared_delay_scheduler_pkg.sv
// Shared types and round-robin pick helper for the delay scheduler.
// rr_pick is written for up to RR_MAX requesters; callers zero-pad narrower vectors.
package shared_delay_scheduler_pkg;

   localparam int RR_MAX = 16;

   typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} sched_state_t;

   // Returns {valid, index}: first set bit searching ptr+1, ptr+2, ... modulo n.
   function automatic logic [4:0] rr_pick(input logic [RR_MAX-1:0] req,
                                          input logic [3:0]        ptr,
                                          input int                n);
      logic [4:0] res;
      int         idx;
      res = '0;
      for (int i = RR_MAX; i >= 1; i--) begin
         if (i <= n) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (req[idx[3:0]]) res = {1'b1, idx[3:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/shared_delay_scheduler_fast_counter.sv
// Split down-counter: 4-bit lsb nibble plus WIDTH-4 msb bits that only move on nibble underflow.
// No reset; always loaded via set before use. Zero flag is combinational from the state.
module fast_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             set,
   input  logic [WIDTH-1:0] set_val,
   input  logic             dec,
   output logic             q_is_zero
);

   localparam logic [WIDTH-5:0] HI_ONE = (WIDTH-4)'(1);

   logic [3:0]       lo_q;
   logic [WIDTH-5:0] hi_q;

   always_ff @(posedge clk) begin
      if (set) begin
         lo_q <= set_val[3:0];
         hi_q <= set_val[WIDTH-1:4];
      end else if (dec) begin
         lo_q <= lo_q - 4'd1;
         if (lo_q == 4'd0) hi_q <= hi_q - HI_ONE;
      end
   end

   assign q_is_zero = (lo_q == 4'd0) && (hi_q == '0);

endmodule

// File: rtl/shared_delay_scheduler.sv
// Round-robin time-sharing of one fast_counter among N_REQ delay requesters.
// ack one cycle after grant; done D+2 cycles after ack; owner cancel aborts in LOAD/COUNT.
module shared_delay_scheduler
   import shared_delay_scheduler_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   req_delay,
   input  logic [N_REQ-1:0]         cancel,
   output logic [N_REQ-1:0]         ack,
   output logic [N_REQ-1:0]         done,
   output logic [N_REQ-1:0]         aborted,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] cur_id
);

   localparam int IDW = $clog2(N_REQ);

   sched_state_t      state_q;
   logic [IDW-1:0]    rr_ptr_q;
   logic [IDW-1:0]    cur_id_q;
   logic [WIDTH-1:0]  delay_q;
   logic [N_REQ-1:0]  ack_q, done_q, aborted_q;
   logic              busy_q;

   logic [RR_MAX-1:0] req_pad;
   logic [3:0]        ptr_pad;
   logic [4:0]        pick_res;
   logic              pick_vld;
   logic [IDW-1:0]    pick_id;
   logic [WIDTH-1:0]  pick_delay;
   logic              cancel_own;
   logic              cnt_set, cnt_dec, cnt_zero;

   always_comb begin
      req_pad               = '0;
      req_pad[N_REQ-1:0]    = req;
      ptr_pad               = '0;
      ptr_pad[IDW-1:0]      = rr_ptr_q;
      pick_res              = rr_pick(req_pad, ptr_pad, N_REQ);
      pick_vld              = pick_res[4];
      pick_id               = IDW'(pick_res[3:0]);
      // Only the winner's delay reaches the counter path.
      pick_delay            = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick_id == IDW'(k)) pick_delay = req_delay[k*WIDTH +: WIDTH];
      end
   end

   assign cancel_own = cancel[cur_id_q];
   assign cnt_set    = (state_q == LOAD);
   assign cnt_dec    = (state_q == COUNT) && !cnt_zero;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= IDLE;
         rr_ptr_q  <= IDW'(N_REQ - 1);
         cur_id_q  <= '0;
         delay_q   <= '0;
         ack_q     <= '0;
         done_q    <= '0;
         aborted_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         ack_q     <= '0;
         done_q    <= '0;
         aborted_q <= '0;
         case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  state_q          <= LOAD;
                  cur_id_q         <= pick_id;
                  rr_ptr_q         <= pick_id;
                  delay_q          <= pick_delay;
                  ack_q[pick_id]   <= 1'b1;
                  busy_q           <= 1'b1;
               end
            end
            LOAD: begin
               if (cancel_own) begin
                  state_q             <= IDLE;
                  aborted_q[cur_id_q] <= 1'b1;
                  busy_q              <= 1'b0;
               end else begin
                  state_q <= COUNT;
               end
            end
            COUNT: begin
               // Cancel beats a simultaneous expiry.
               if (cancel_own) begin
                  state_q             <= IDLE;
                  aborted_q[cur_id_q] <= 1'b1;
                  busy_q              <= 1'b0;
               end else if (cnt_zero) begin
                  state_q          <= DONE;
                  done_q[cur_id_q] <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   fast_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk       (clk),
      .set       (cnt_set),
      .set_val   (delay_q),
      .dec       (cnt_dec),
      .q_is_zero (cnt_zero)
   );

   assign ack     = ack_q;
   assign done    = done_q;
   assign aborted = aborted_q;
   assign busy    = busy_q;
   assign cur_id  = cur_id_q;

endmodule
